// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: op codes, op count and FSM states.
package alu_pkg;

    localparam int unsigned NOPS = 12;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of a 4-bit op code into a one-hot ALU select plus invalid flag.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned NOPS = 12
) (
    input  logic [3:0]      i_op,
    output logic [NOPS-1:0] o_onehot,
    output logic            o_invalid
);

    always_comb begin
        o_onehot  = '0;
        o_invalid = (32'(i_op) >= NOPS);
        for (int unsigned i = 0; i < NOPS; i++) begin
            o_onehot[i] = (32'(i_op) == i);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer for the shared external ALU: accept, execute, respond.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NOPS = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    output logic [NOPS-1:0] alu_control,
    output logic [DW-1:0]   alu_src1,
    output logic [DW-1:0]   alu_src2,
    input  logic [DW-1:0]   alu_result,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [DW-1:0]   resp_result,
    output logic            resp_err,
    output logic            busy
);

    state_t          r_state;
    logic            r_last_grant;
    logic [NOPS-1:0] r_alu_control;
    logic [DW-1:0]   r_src1;
    logic [DW-1:0]   r_src2;
    logic            r_pend_id;
    logic            r_pend_err;
    logic            r_resp_valid;
    logic            r_resp_id;
    logic [DW-1:0]   r_resp_result;
    logic            r_resp_err;
    logic            r_busy;

    logic            w_accept;
    logic            w_win1;
    logic [3:0]      w_win_op;
    logic [DW-1:0]   w_win_a;
    logic [DW-1:0]   w_win_b;
    logic [NOPS-1:0] w_dec_onehot;
    logic            w_dec_invalid;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        w_win1   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_accept = (r_state == ST_IDLE) && (req0_valid || req1_valid);
        w_win_op = w_win1 ? req1_op : req0_op;
        w_win_a  = w_win1 ? req1_a  : req0_a;
        w_win_b  = w_win1 ? req1_b  : req0_b;
    end

    assign req0_ready = w_accept && !w_win1;
    assign req1_ready = w_accept &&  w_win1;

    alu_op_decode #(
        .NOPS (NOPS)
    ) u_decode (
        .i_op      (w_win_op),
        .o_onehot  (w_dec_onehot),
        .o_invalid (w_dec_invalid)
    );

    // The one-hot select is decoded at accept and loaded so it is live only during EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_alu_control <= '0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_pend_id     <= 1'b0;
            r_pend_err    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src1        <= w_win_a;
                        r_src2        <= w_win_b;
                        r_alu_control <= w_dec_onehot;
                        r_pend_err    <= w_dec_invalid;
                        r_pend_id     <= w_win1;
                        r_last_grant  <= w_win1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_alu_control <= '0;
                    r_resp_result <= r_pend_err ? '0 : alu_result;
                    r_resp_id     <= r_pend_id;
                    r_resp_err    <= r_pend_err;
                    r_resp_valid  <= 1'b1;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_alu_control <= '0;
                    r_resp_valid  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_control = r_alu_control;
    assign alu_src1    = r_src1;
    assign alu_src2    = r_src2;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and arbitration reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [11:0] alu_control;
    logic [31:0] alu_src1, alu_src2;
    logic [31:0] alu_result;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_err;
    logic        busy;

    alu_arbiter #(
        .DW   (32),
        .NOPS (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .alu_control (alu_control),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return $signed(a) >>> b[4:0];
            11: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [11:0] exp_ctrl(input logic [3:0] op);
        logic [11:0] one;
        one = 12'd1;
        return (op < 4'd12) ? (one << op) : 12'd0;
    endfunction

    // External ALU: only a strictly one-hot select yields a real result.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        for (int i = 0; i < 12; i++) begin
            if (alu_control == (12'd1 << i)) alu_result = ref_alu(i, alu_src1, alu_src2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          d_log[$];
    logic        p_v[2];
    logic [3:0]  p_op[2];
    logic [31:0] p_a[2];
    logic [31:0] p_b[2];
    logic        rr = 1'b1;
    int          m_phase = 0;
    int          m_last = 1;
    logic [3:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_res;
    logic        prev_id, prev_err;
    logic [31:0] last_res = '0;
    logic        last_id = 1'b0, last_err = 1'b0;

    task automatic load(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        p_v[p] = 1'b1; p_op[p] = op; p_a[p] = a; p_b[p] = b;
    endtask

    task automatic load_rand(input int p);
        logic [31:0] b;
        b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
        load(p, 4'($urandom_range(0, 15)), $urandom, b);
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step();
        int   win;
        exp_t e;
        @(negedge clk);
        req0_valid = p_v[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = p_v[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
        resp_ready = rr;
        #1;
        win = -1;
        if (m_phase == 0 && (p_v[0] || p_v[1]))
            win = (p_v[0] && p_v[1]) ? 1 - m_last : (p_v[1] ? 1 : 0);
        if (req0_ready) d_log.push_back(0);
        if (req1_ready) d_log.push_back(1);
        chk("req0_ready", 32'(req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(req1_ready), 32'(win == 1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
        chk("alu_control", 32'(alu_control), (m_phase == 1) ? 32'(exp_ctrl(m_op)) : 32'd0);
        if (m_phase == 1) begin
            chk("alu_src1", alu_src1, m_a);
            chk("alu_src2", alu_src2, m_b);
        end
        @(posedge clk);
        case (m_phase)
            0: if (win >= 0) begin
                e.id  = win;
                e.err = (p_op[win] >= 4'd12);
                e.res = e.err ? 32'd0 : ref_alu(int'(p_op[win]), p_a[win], p_b[win]);
                sbq.push_back(e);
                m_last = win; m_op = p_op[win]; m_a = p_a[win]; m_b = p_b[win];
                p_v[win] = 1'b0;
                m_phase = 1;
            end
            1: m_phase = 2;
            default: if (rr) m_phase = 0;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; p_v[0] = 1'b0; p_v[1] = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_req1_ready", 32'(req1_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_control", 32'(alu_control), 0);
        chk("rst_alu_src1", alu_src1, 0);
        chk("rst_alu_src2", alu_src2, 0);
        #1;
        reset = 1'b0;
        m_phase = 0; m_last = 1; hold_prev = 1'b0;
        sbq.delete();
    endtask

    // Monitor: pops the scoreboard on each response handshake and checks hold stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                hold_prev = 1'b0;
                continue;
            end
            if (hold_prev) begin
                chk("hold_valid", 32'(resp_valid), 1);
                chk("hold_result", resp_result, prev_res);
                chk("hold_id", 32'(resp_id), 32'(prev_id));
                chk("hold_err", 32'(resp_err), 32'(prev_err));
            end
            hold_prev = resp_valid && !resp_ready;
            prev_res = resp_result; prev_id = resp_id; prev_err = resp_err;
            if (resp_valid && resp_ready) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected actual=id%0d/%h required=no response", resp_id, resp_result);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                    chk("resp_result", resp_result, e.res);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    last_res = resp_result; last_id = resp_id; last_err = resp_err;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[2];
        int n;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; end
        do_reset();

        // Tie and fairness: both ports continuously valid, four ops each.
        d_log.delete();
        rr = 1'b1;
        cnt[0] = 4; cnt[1] = 4;
        n = 0;
        while (d_log.size() < 8 && n < 60) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && cnt[p] > 0) begin load_rand(p); cnt[p]--; end
            end
            step();
            n++;
        end
        chk("fair_grants", 32'(d_log.size()), 8);
        for (int i = 0; i < d_log.size() && i < 8; i++) chk("fair_order", 32'(d_log[i]), 32'(i % 2));
        repeat (4) step();

        // Single request: add 5 + 3.
        load(0, 4'd0, 32'h5, 32'h3);
        repeat (4) step();
        chk("single_result", last_res, 32'h8);
        chk("single_id", 32'(last_id), 0);
        chk("single_err", 32'(last_err), 0);

        // Response backpressure with port 1 waiting.
        load(0, 4'd7, $urandom, $urandom);
        step();
        load(1, 4'd1, $urandom, $urandom);
        rr = 1'b0;
        repeat (6) step();
        rr = 1'b1;
        d_log.delete();
        step();
        step();
        chk("bp_accept_after", 32'(d_log.size() == 1 && d_log[0] == 1), 1);
        repeat (3) step();

        // Invalid op on port 1.
        load(1, 4'd13, $urandom, $urandom);
        repeat (4) step();
        chk("inv_result", last_res, 0);
        chk("inv_err", 32'(last_err), 1);
        chk("inv_id", 32'(last_id), 1);

        // Arithmetic shift right.
        load(0, 4'd10, 32'h80000000, 32'd4);
        repeat (4) step();
        chk("sra_result", last_res, 32'hF8000000);

        // Reset while in EXEC, then a tie must go to port 0.
        load(1, 4'd0, $urandom, $urandom);
        step();
        do_reset();
        load(0, 4'd6, $urandom, $urandom);
        load(1, 4'd6, $urandom, $urandom);
        d_log.delete();
        step();
        chk("post_reset_tie", 32'(d_log.size() == 1 && d_log[0] == 0), 1);
        repeat (8) step();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++)
                if (!p_v[p] && $urandom_range(0, 2) == 0) load_rand(p);
            rr = ($urandom_range(0, 3) != 0);
            step();
        end

        p_v[0] = 1'b0; p_v[1] = 1'b0; rr = 1'b1;
        repeat (8) step();
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
